// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: forward-select
// encodings, register-index width and the layout of a shadow pipeline entry.
package id_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;
    localparam logic [REG_W-1:0] REG_ZERO      = 5'd0;

    // One shadow entry mirrors the hazard-relevant part of an in-flight
    // instruction. rd is already zeroed for instructions that do not write.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use1;
        logic             use2;
    } hz_entry_t;

    localparam int HZ_W = $bits(hz_entry_t);

    localparam hz_entry_t HZ_BUBBLE = '{
        valid: 1'b0,
        rd:    5'd0,
        load:  1'b0,
        rs1:   5'd0,
        rs2:   5'd0,
        use1:  1'b0,
        use2:  1'b0
    };

    // True when the producer entry writes the register a consumer reads.
    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic rd_match(input hz_entry_t prod,
                                      input logic [REG_W-1:0] rs,
                                      input logic use_rs);
        return prod.valid & use_rs & (prod.rd != REG_ZERO) & (prod.rd == rs);
    endfunction

    // Pick the youngest producer: MEM result beats the older WB result.
    function automatic logic [1:0] fwd_select(input hz_entry_t mem_ent,
                                              input hz_entry_t wb_ent,
                                              input logic [REG_W-1:0] rs,
                                              input logic use_rs);
        logic [1:0] sel;
        if (rd_match(mem_ent, rs, use_rs)) begin
            sel = FWD_MEM;
        end else if (rd_match(wb_ent, rs, use_rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline register (E, M or W). Holds while disabled; when
// enabled it either loads the upstream entry or becomes a bubble.
module hz_stage_reg
    import id_hazard_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [HZ_W-1:0] d,
    output logic [HZ_W-1:0] q
);

    logic [HZ_W-1:0] entry_r;

    // Shadow entry: reset and clear both produce a bubble, disable holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_r <= HZ_BUBBLE;
        end else if (en) begin
            if (clr) begin
                entry_r <= HZ_BUBBLE;
            end else begin
                entry_r <= d;
            end
        end
    end

    assign q = entry_r;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller for a 5-stage in-order pipeline. Tracks the
// instructions in EX/MEM/WB with shadow entries, detects load-use hazards,
// drives stall/flush controls and the EX operand forward selects, and counts
// load-use stall cycles.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ValidD,
    input  logic [4:0]  i_Rs1D,
    input  logic [4:0]  i_Rs2D,
    input  logic [4:0]  i_RdD,
    input  logic        i_UseRs1D,
    input  logic        i_UseRs2D,
    input  logic        i_WrRdD,
    input  logic        i_LoadD,
    input  logic        i_RedirectE,
    input  logic        i_BusyE,
    output logic        o_StallF,
    output logic        o_StallD,
    output logic        o_FlushD,
    output logic        o_FlushE,
    output logic [1:0]  o_Fwd1SelE,
    output logic [1:0]  o_Fwd2SelE,
    output logic [15:0] o_StallCnt
);

    hz_entry_t        id_ent_s;
    hz_entry_t        e_ent_s;
    hz_entry_t        m_ent_s;
    hz_entry_t        w_ent_s;
    logic [HZ_W-1:0]  e_q_s;
    logic [HZ_W-1:0]  m_q_s;
    logic [HZ_W-1:0]  w_q_s;

    logic             redir_pend_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             redirect_s;
    logic             load_use_s;
    logic             lu_stall_s;
    logic             stall_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic             shift_en_s;
    logic             e_clr_s;
    logic [1:0]       fwd1_s;
    logic [1:0]       fwd2_s;

    assign e_ent_s = e_q_s;
    assign m_ent_s = m_q_s;
    assign w_ent_s = w_q_s;

    // Build the entry that would be issued from ID; non-writers carry rd=0.
    always_comb begin
        id_ent_s       = HZ_BUBBLE;
        id_ent_s.valid = i_ValidD;
        id_ent_s.load  = i_LoadD;
        id_ent_s.rs1   = i_Rs1D;
        id_ent_s.rs2   = i_Rs2D;
        id_ent_s.use1  = i_UseRs1D;
        id_ent_s.use2  = i_UseRs2D;
        if (i_WrRdD) begin
            id_ent_s.rd = i_RdD;
        end else begin
            id_ent_s.rd = REG_ZERO;
        end
    end

    // A redirect seen while EX is busy is remembered until EX frees up.
    assign redirect_s = i_RedirectE | redir_pend_r;

    // Load in EX whose result the ID instruction needs next cycle.
    assign load_use_s = i_ValidD & e_ent_s.load &
                        (rd_match(e_ent_s, i_Rs1D, i_UseRs1D) |
                         rd_match(e_ent_s, i_Rs2D, i_UseRs2D));

    // Stall/flush priority: busy EX, then redirect, then load-use.
    always_comb begin
        stall_s    = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        lu_stall_s = 1'b0;
        if (i_BusyE) begin
            stall_s = 1'b1;
        end else if (redirect_s) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (load_use_s) begin
            stall_s    = 1'b1;
            flush_e_s  = 1'b1;
            lu_stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Forward selects for the instruction currently in EX.
    always_comb begin
        fwd1_s = fwd_select(m_ent_s, w_ent_s, e_ent_s.rs1, e_ent_s.use1);
        fwd2_s = fwd_select(m_ent_s, w_ent_s, e_ent_s.rs2, e_ent_s.use2);
    end

    // The shadow pipe freezes with EX; EX gets a bubble on flush or empty ID.
    assign shift_en_s = ~i_BusyE;
    assign e_clr_s    = flush_e_s | ~i_ValidD;

    hz_stage_reg u_stage_e (
        .clk (clk),
        .rst (rst),
        .en  (shift_en_s),
        .clr (e_clr_s),
        .d   (id_ent_s),
        .q   (e_q_s)
    );

    hz_stage_reg u_stage_m (
        .clk (clk),
        .rst (rst),
        .en  (shift_en_s),
        .clr (1'b0),
        .d   (e_q_s),
        .q   (m_q_s)
    );

    hz_stage_reg u_stage_w (
        .clk (clk),
        .rst (rst),
        .en  (shift_en_s),
        .clr (1'b0),
        .d   (m_q_s),
        .q   (w_q_s)
    );

    // Remember a redirect raised during busy; drop it once it is honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_pend_r <= 1'b0;
        end else if (i_BusyE) begin
            redir_pend_r <= redir_pend_r | i_RedirectE;
        end else begin
            redir_pend_r <= 1'b0;
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (lu_stall_s && (stall_cnt_r != STALL_CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign o_StallF   = stall_s;
    assign o_StallD   = stall_s;
    assign o_FlushD   = flush_d_s;
    assign o_FlushE   = flush_e_s;
    assign o_Fwd1SelE = fwd1_s;
    assign o_Fwd2SelE = fwd2_s;
    assign o_StallCnt = stall_cnt_r;

endmodule
